fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 159 +++++++++++++++
 tb/tb_fetch_unit.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: issues sequential instruction fetches and buffers in-order responses for a consumer.
// Defining FETCH_UNIT_PERF_EN adds the perf_fetched / perf_flushed counters.
//
// state | meaning
// IDLE  | first cycle after reset release, nothing issued
// FETCH | issuing requests while credit allows, responses fill the buffer
// FLUSH | redirected; dropping responses that belong to the abandoned path

module fetch_unit #(
    parameter int              XLEN       = 64,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic            clock,
    input  logic            reset_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr
`ifdef FETCH_UNIT_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_flushed
`endif
);

    localparam int              PW      = $clog2(FIFO_DEPTH);
    localparam int              CW      = PW + 1;
    localparam logic [XLEN-1:0] ALIGN   = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
    localparam logic [CW:0]     DEPTH_W = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] fetch_pc, rsp_pc, redirect_tgt;
    logic [CW-1:0]   outstanding, discard, discard_nxt, redirect_discard, fifo_count;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [XLEN-1:0] pc_mem    [FIFO_DEPTH];
    logic [31:0]     instr_mem [FIFO_DEPTH];
    logic            req_fire, pop_fire, do_push, do_redirect, credit_ok;

    assign redirect_tgt     = redirect_pc & ALIGN;
    assign redirect_discard = outstanding - CW'(imem_rsp_valid);
    assign credit_ok        = ({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_W;
    assign req_fire         = imem_req_valid & imem_req_ready;
    assign imem_req_addr    = fetch_pc & ALIGN;
    assign out_valid        = (fifo_count != '0);
    assign pop_fire         = out_valid & out_ready;
    assign out_pc           = pc_mem[rd_ptr];
    assign out_instr        = instr_mem[rd_ptr];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            discard <= '0;
        end else begin
            state   <= state_nxt;
            discard <= discard_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        discard_nxt    = discard;
        imem_req_valid = 1'b0;
        do_push        = 1'b0;
        do_redirect    = 1'b0;
        unique case (state)
            IDLE: state_nxt = FETCH;
            FETCH: begin
                if (redirect_valid) begin
                    do_redirect = 1'b1;
                end else begin
                    imem_req_valid = credit_ok;
                    do_push        = imem_rsp_valid;
                end
            end
            FLUSH: begin
                if (redirect_valid) begin
                    do_redirect = 1'b1;
                end else if (imem_rsp_valid) begin
                    discard_nxt = discard - CW'(1);
                    if (discard_nxt == '0)
                        state_nxt = FETCH;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // A response landing with the redirect belongs to the old path, so it is not waited for.
        if (do_redirect) begin
            discard_nxt = redirect_discard;
            state_nxt   = (redirect_discard != '0) ? FLUSH : FETCH;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc    <= RESET_PC & ALIGN;
            rsp_pc      <= RESET_PC & ALIGN;
            outstanding <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
            if (do_redirect) begin
                fetch_pc   <= redirect_tgt;
                rsp_pc     <= redirect_tgt;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_count <= '0;
            end else begin
                if (req_fire)
                    fetch_pc <= fetch_pc + PC_STEP;
                if (do_push) begin
                    pc_mem[wr_ptr]    <= rsp_pc;
                    instr_mem[wr_ptr] <= imem_rsp_data;
                    wr_ptr            <= wr_ptr + PW'(1);
                    rsp_pc            <= rsp_pc + PC_STEP;
                end
                if (pop_fire)
                    rd_ptr <= rd_ptr + PW'(1);
                fifo_count <= fifo_count + CW'(do_push) - CW'(pop_fire);
            end
        end
    end

`ifdef FETCH_UNIT_PERF_EN
    logic [31:0] flush_cleared;
    logic        flush_drop;

    // An entry popped in the redirect cycle was delivered, so it is not counted as flushed.
    assign flush_cleared = do_redirect ? (32'(fifo_count) - 32'(pop_fire)) : 32'd0;
    assign flush_drop    = (state == FLUSH) & imem_rsp_valid;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            perf_fetched <= perf_fetched + 32'(do_push);
            perf_flushed <= perf_flushed + flush_cleared + 32'(flush_drop);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, then random traffic against a queue-level model
// with an in-order memory of random latency; async reset applied mid-stream.
module tb_fetch_unit;

    localparam int DEPTH = 4;

    logic        clock          = 1'b0;
    logic        reset_n        = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = '0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc    = '0;
    logic        out_valid;
    logic        out_ready      = 1'b0;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
`ifdef FETCH_UNIT_PERF_EN
    logic [31:0] perf_fetched, perf_flushed;
`endif

    always #5 clock = ~clock;

    fetch_unit #(.XLEN(64), .RESET_PC(64'h0), .FIFO_DEPTH(DEPTH)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
`ifdef FETCH_UNIT_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_flushed   (perf_flushed)
`endif
    );

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic        rr;
        logic        rsp;
        logic [63:0] raddr;
        logic        orr;
        logic        redir;
        logic [63:0] rpc;
        logic        erv;
        logic [63:0] eaddr;
        logic        eov;
        logic [63:0] epc;
    } vec_t;
    vec_t tbl[$];

    typedef struct { logic [63:0] pc; logic [31:0] instr; } ent_t;
    typedef struct { logic [63:0] addr; int due; } mreq_t;

    ent_t        mq[$];
    mreq_t       memq[$];
    int          m_mode;
    logic [63:0] m_fpc, m_rpc;
    int          m_out, m_disc, last_due;
    logic [31:0] m_fetched, m_flushed;

    function automatic logic [31:0] word_at(input logic [63:0] a);
        return 32'h5EED_0000 ^ a[31:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic rr, input logic rsp, input logic [63:0] raddr, input logic orr,
                           input logic redir, input logic [63:0] rpc, input logic erv,
                           input logic [63:0] eaddr, input logic eov, input logic [63:0] epc);
        vec_t v;
        v = '{rr: rr, rsp: rsp, raddr: raddr, orr: orr, redir: redir, rpc: rpc,
              erv: erv, eaddr: eaddr, eov: eov, epc: epc};
        tbl.push_back(v);
    endtask

    task automatic drive(input logic rr, input logic rsp, input logic [31:0] rdata, input logic orr,
                         input logic redir, input logic [63:0] rpc);
        imem_req_ready = rr;
        imem_rsp_valid = rsp;
        imem_rsp_data  = rdata;
        out_ready      = orr;
        redirect_valid = redir;
        redirect_pc    = rpc;
    endtask

    task automatic model_reset();
        m_mode = 0; m_fpc = '0; m_rpc = '0; m_out = 0; m_disc = 0;
        mq.delete(); memq.delete(); last_due = -1;
        m_fetched = '0; m_flushed = '0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".req_valid"}, 64'(imem_req_valid), 64'd0);
        check({tag, ".out_valid"}, 64'(out_valid), 64'd0);
        check({tag, ".out_pc"}, out_pc, 64'd0);
        check({tag, ".out_instr"}, 64'(out_instr), 64'd0);
`ifdef FETCH_UNIT_PERF_EN
        check({tag, ".perf_fetched"}, 64'(perf_fetched), 64'd0);
        check({tag, ".perf_flushed"}, 64'(perf_flushed), 64'd0);
`endif
    endtask

    // Asserted between edges: outputs must fall without waiting for a clock.
    task automatic do_reset(input string tag);
        drive(0, 0, '0, 0, 0, '0);
        reset_n = 1'b0;
        #1;
        check_reset_values(tag);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, n_bad=%0d", n_bad);
        $fatal(1, "time limit");
    end

    initial begin
        logic        rr, orr, redir, rsp, exp_rv, pop, fire;
        logic [63:0] rpc, raddr, tgt;
        int          lat, due;

        // rr rsp raddr orr redir rpc | erv eaddr eov epc
        add_vec(1, 0, 0,      1, 0, 0,        0, 0,      0, 0);      // IDLE
        add_vec(1, 0, 0,      1, 0, 0,        1, 0,      0, 0);
        add_vec(1, 1, 0,      1, 0, 0,        1, 4,      0, 0);
        add_vec(1, 1, 4,      1, 0, 0,        1, 8,      1, 0);      // one-cycle buffer latency
        add_vec(1, 1, 8,      0, 0, 0,        1, 12,     1, 4);
        add_vec(1, 1, 12,     0, 0, 0,        1, 16,     1, 4);
        add_vec(1, 1, 16,     0, 0, 0,        0, 0,      1, 4);      // credit exhausted
        add_vec(1, 0, 0,      0, 0, 0,        0, 0,      1, 4);      // buffer full
        add_vec(1, 0, 0,      1, 0, 0,        0, 0,      1, 4);
        add_vec(1, 0, 0,      1, 0, 0,        1, 20,     1, 8);
        add_vec(1, 0, 0,      0, 0, 0,        1, 24,     1, 12);
        add_vec(1, 0, 0,      0, 1, 64'h1000, 0, 0,      1, 12);     // redirect, 2 outstanding
        add_vec(1, 1, 20,     1, 0, 0,        0, 0,      0, 0);      // dropped
        add_vec(1, 1, 24,     1, 0, 0,        0, 0,      0, 0);      // dropped
        add_vec(1, 0, 0,      1, 0, 0,        1, 64'h1000, 0, 0);
        add_vec(1, 1, 64'h1000, 1, 0, 0,      1, 64'h1004, 0, 0);
        add_vec(0, 0, 0,      1, 0, 0,        1, 64'h1008, 1, 64'h1000);
        add_vec(1, 1, 64'h1004, 1, 1, 64'h2002, 0, 0,    0, 0);      // redirect + response, discard 0
        add_vec(1, 0, 0,      1, 0, 0,        1, 64'h2000, 0, 0);
        add_vec(0, 1, 64'h2000, 1, 0, 0,      1, 64'h2004, 0, 0);
        add_vec(0, 0, 0,      1, 0, 0,        1, 64'h2004, 1, 64'h2000);
        add_vec(1, 0, 0,      1, 0, 0,        1, 64'h2004, 0, 0);
        add_vec(0, 1, 64'h2004, 1, 0, 0,      1, 64'h2008, 0, 0);
        add_vec(1, 0, 0,      1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 1, 64'h2004); // pop + redirect
        add_vec(1, 0, 0,      1, 0, 0,        1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0);
        add_vec(1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 0, 1, 0, 0, 0);          // address wrap
        add_vec(0, 1, 0,      1, 0, 0,        1, 4,      1, 64'hFFFF_FFFF_FFFF_FFFC);
        add_vec(0, 0, 0,      1, 0, 0,        1, 4,      1, 0);

        drive(0, 0, '0, 0, 0, '0);
        #11;
        check_reset_values("por");
        reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rr, tbl[i].rsp, word_at(tbl[i].raddr), tbl[i].orr, tbl[i].redir, tbl[i].rpc);
            #1;
            check($sformatf("tbl[%0d].req_valid", i), 64'(imem_req_valid), 64'(tbl[i].erv));
            if (tbl[i].erv)
                check($sformatf("tbl[%0d].req_addr", i), imem_req_addr, tbl[i].eaddr);
            check($sformatf("tbl[%0d].out_valid", i), 64'(out_valid), 64'(tbl[i].eov));
            if (tbl[i].eov) begin
                check($sformatf("tbl[%0d].out_pc", i), out_pc, tbl[i].epc);
                check($sformatf("tbl[%0d].out_instr", i), 64'(out_instr), 64'(word_at(tbl[i].epc)));
            end
            @(posedge clock); #1;
        end

        do_reset("rst_after_tbl");

        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc == 2000)
                do_reset("rst_mid_rand");
            rr    = ($urandom_range(3) != 0);
            orr   = ($urandom_range(3) != 0);
            redir = ($urandom_range(24) == 0);
            case ($urandom_range(2))
                0:       rpc = {$urandom, $urandom};
                1:       rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15));
                default: rpc = 64'($urandom_range(16'hFFFF));
            endcase
            rsp   = (memq.size() > 0) && (memq[0].due <= cyc);
            raddr = '0;
            if (rsp) begin
                raddr = memq[0].addr;
                void'(memq.pop_front());
            end
            drive(rr, rsp, word_at(raddr), orr, redir, rpc);
            #1;

            exp_rv = (m_mode == 1) && (m_out + mq.size() < DEPTH) && !redir;
            check($sformatf("rnd[%0d].req_valid", cyc), 64'(imem_req_valid), 64'(exp_rv));
            if (exp_rv)
                check($sformatf("rnd[%0d].req_addr", cyc), imem_req_addr, m_fpc);
            check($sformatf("rnd[%0d].out_valid", cyc), 64'(out_valid), 64'(mq.size() > 0));
            if (mq.size() > 0) begin
                check($sformatf("rnd[%0d].out_pc", cyc), out_pc, mq[0].pc);
                check($sformatf("rnd[%0d].out_instr", cyc), 64'(out_instr), 64'(mq[0].instr));
            end
`ifdef FETCH_UNIT_PERF_EN
            check($sformatf("rnd[%0d].perf_fetched", cyc), 64'(perf_fetched), 64'(m_fetched));
            check($sformatf("rnd[%0d].perf_flushed", cyc), 64'(perf_flushed), 64'(m_flushed));
`endif

            pop  = (mq.size() > 0) && orr;
            fire = exp_rv && rr;
            if (fire) begin
                lat = int'($urandom_range(3, 1));
                due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                memq.push_back('{addr: m_fpc, due: due});
                last_due = due;
            end
            if (m_mode == 0) begin
                m_mode = 1;
            end else if (redir) begin
                m_flushed = m_flushed + 32'(mq.size()) - 32'(pop);
                if (m_mode == 2 && rsp)
                    m_flushed = m_flushed + 32'd1;
                mq.delete();
                tgt   = rpc & ~64'h3;
                m_fpc = tgt;
                m_rpc = tgt;
                if (rsp) m_out--;
                m_disc = m_out;
                m_mode = (m_disc > 0) ? 2 : 1;
            end else begin
                if (pop) void'(mq.pop_front());
                if (fire) begin
                    m_fpc = m_fpc + 64'd4;
                    m_out++;
                end
                if (rsp) begin
                    m_out--;
                    if (m_mode == 1) begin
                        mq.push_back('{pc: m_rpc, instr: word_at(raddr)});
                        m_rpc     = m_rpc + 64'd4;
                        m_fetched = m_fetched + 32'd1;
                    end else begin
                        m_disc--;
                        m_flushed = m_flushed + 32'd1;
                        if (m_disc == 0) m_mode = 1;
                    end
                end
            end
            @(posedge clock); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
